// File: rtl/compfir_pkg.sv
// Shared types and arithmetic helpers for the compensation FIR and sibling DSP blocks.
package compfir_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_SAT, ST_OUT} state_e;

   localparam int WIDE_W = 128;
   typedef logic signed [WIDE_W-1:0] wide_t;

   function automatic int acc_width(input int w, input int cw, input int taps);
      return w + cw + $clog2(taps);
   endfunction

   function automatic int chan_width(input int nch);
      return (nch > 1) ? $clog2(nch) : 1;
   endfunction

   // Round half up, drop frac_bits, clamp to the out_w-bit signed range.
   function automatic wide_t round_sat(input wide_t acc, input int frac_bits, input int out_w);
      wide_t one, v, hi, lo;
      one = wide_t'(1);
      v   = acc;
      if (frac_bits > 0) v = v + (one <<< (frac_bits - 1));
      v  = v >>> frac_bits;
      hi = (one <<< (out_w - 1)) - one;
      lo = -(one <<< (out_w - 1));
      if (v > hi) v = hi;
      else if (v < lo) v = lo;
      return v;
   endfunction

endpackage

// File: rtl/compfir_hist_ram.sv
// Per-channel circular sample history; tap k reads the k-th most recent sample of a channel.
module compfir_hist_ram
   import compfir_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int TAPS  = 16,
   parameter int NCH   = 2,
   localparam int CW   = chan_width(NCH),
   localparam int TW   = $clog2(TAPS)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    we,
   input  logic [CW-1:0]           wr_chan,
   input  logic signed [WIDTH-1:0] wr_data,
   input  logic [CW-1:0]           rd_chan,
   input  logic [TW-1:0]           rd_tap,
   output logic signed [WIDTH-1:0] rd_data
);

   localparam int DEPTH = NCH * TAPS;
   localparam int AIW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int NPTR  = 2 ** CW;

   logic signed [WIDTH-1:0] mem_q [DEPTH];
   logic signed [WIDTH-1:0] mem_d [DEPTH];
   logic [TW-1:0]           wptr_q [NPTR];
   logic [TW-1:0]           wptr_d [NPTR];
   logic [AIW-1:0]          wr_idx;
   logic [AIW-1:0]          rd_idx;
   int                      rd_slot;

   // wptr points at the slot the next sample of that channel will occupy
   always_comb begin
      mem_d  = mem_q;
      wptr_d = wptr_q;
      wr_idx = AIW'(int'(wr_chan) * TAPS + int'(wptr_q[wr_chan]));
      if (we) begin
         mem_d[wr_idx]   = wr_data;
         wptr_d[wr_chan] = (wptr_q[wr_chan] == TW'(TAPS - 1)) ? '0 : wptr_q[wr_chan] + TW'(1);
      end
   end

   always_comb begin
      rd_slot = int'(wptr_q[rd_chan]) - 1 - int'(rd_tap);
      if (rd_slot < 0) rd_slot = rd_slot + TAPS;
      rd_idx  = AIW'(int'(rd_chan) * TAPS + rd_slot);
      rd_data = mem_q[rd_idx];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         for (int i = 0; i < NPTR; i++) wptr_q[i] <= '0;
      end else begin
         mem_q  <= mem_d;
         wptr_q <= wptr_d;
      end
   end

endmodule

// File: rtl/compensation_fir_mc.sv
// Multi-channel decimating CIC droop-compensation FIR built around one time-shared MAC.
module compensation_fir_mc
   import compfir_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int COEFF_WIDTH = 16,
   parameter int TAPS        = 16,
   parameter int NCH         = 2,
   parameter int DECIM       = 8,
   parameter int FRAC_BITS   = COEFF_WIDTH - 2,
   localparam int CW         = chan_width(NCH),
   localparam int TW         = $clog2(TAPS)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic signed [WIDTH-1:0]       in_data,
   input  logic [CW-1:0]                 in_chan,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic                          coeff_we,
   input  logic [TW-1:0]                 coeff_addr,
   input  logic signed [COEFF_WIDTH-1:0] coeff_data,
   output logic                          coeff_ready,
   output logic signed [WIDTH-1:0]       out_data,
   output logic [CW-1:0]                 out_chan,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic                          chan_err
);

   localparam int AW   = acc_width(WIDTH, COEFF_WIDTH, TAPS);
   localparam int PW   = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam int NPH  = 2 ** CW;
   localparam int PRW  = WIDTH + COEFF_WIDTH;
   localparam logic signed [COEFF_WIDTH-1:0] COEFF_ONE = COEFF_WIDTH'(1 << FRAC_BITS);

   function automatic logic signed [WIDTH-1:0] sat_out(input logic signed [AW-1:0] a);
      return WIDTH'(round_sat(wide_t'(a), FRAC_BITS, WIDTH));
   endfunction

   state_e                        state_q, state_d;
   logic [TW-1:0]                 tap_q, tap_d;
   logic [CW-1:0]                 chan_q, chan_d;
   logic signed [AW-1:0]          acc_q, acc_d;
   logic signed [COEFF_WIDTH-1:0] coeff_q [TAPS];
   logic signed [COEFF_WIDTH-1:0] coeff_d [TAPS];
   logic [PW-1:0]                 ph_q [NPH];
   logic [PW-1:0]                 ph_d [NPH];
   logic                          in_ready_q, in_ready_d;
   logic                          coeff_ready_q, coeff_ready_d;
   logic                          out_valid_q, out_valid_d;
   logic signed [WIDTH-1:0]       out_data_q, out_data_d;
   logic [CW-1:0]                 out_chan_q, out_chan_d;
   logic                          chan_err_q, chan_err_d;

   logic                          accept, chan_ok, push, trig;
   logic signed [WIDTH-1:0]       hist_rd;
   logic signed [PRW-1:0]         prod;

   assign accept  = in_valid & in_ready_q;
   assign chan_ok = (int'(in_chan) < NCH);
   assign push    = accept & chan_ok;
   assign trig    = push & (ph_q[in_chan] == PW'(DECIM - 1));
   assign prod    = hist_rd * coeff_q[tap_q];

   compfir_hist_ram #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS),
      .NCH   (NCH)
   ) u_hist (
      .clk     (clk),
      .rst     (rst),
      .we      (push),
      .wr_chan (in_chan),
      .wr_data (in_data),
      .rd_chan (chan_q),
      .rd_tap  (tap_q),
      .rd_data (hist_rd)
   );

   always_comb begin
      state_d     = state_q;
      tap_d       = tap_q;
      chan_d      = chan_q;
      acc_d       = acc_q;
      coeff_d     = coeff_q;
      ph_d        = ph_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_chan_d  = out_chan_q;
      chan_err_d  = accept & ~chan_ok;

      if (coeff_we && coeff_ready_q) coeff_d[coeff_addr] = coeff_data;
      if (push) ph_d[in_chan] = trig ? '0 : ph_q[in_chan] + PW'(1);

      case (state_q)
         ST_IDLE: begin
            if (trig) begin
               state_d = ST_MAC;
               chan_d  = in_chan;
               tap_d   = '0;
               acc_d   = '0;
            end
         end
         ST_MAC: begin
            acc_d = acc_q + AW'(prod);
            if (tap_q == TW'(TAPS - 1)) state_d = ST_SAT;
            else tap_d = tap_q + TW'(1);
         end
         ST_SAT: begin
            out_data_d  = sat_out(acc_q);
            out_chan_d  = chan_q;
            out_valid_d = 1'b1;
            state_d     = ST_OUT;
         end
         ST_OUT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      in_ready_d    = (state_d == ST_IDLE);
      coeff_ready_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         tap_q         <= '0;
         chan_q        <= '0;
         acc_q         <= '0;
         for (int i = 0; i < TAPS; i++) coeff_q[i] <= (i == 0) ? COEFF_ONE : '0;
         for (int i = 0; i < NPH; i++) ph_q[i] <= '0;
         in_ready_q    <= 1'b1;
         coeff_ready_q <= 1'b1;
         out_valid_q   <= 1'b0;
         out_data_q    <= '0;
         out_chan_q    <= '0;
         chan_err_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         tap_q         <= tap_d;
         chan_q        <= chan_d;
         acc_q         <= acc_d;
         coeff_q       <= coeff_d;
         ph_q          <= ph_d;
         in_ready_q    <= in_ready_d;
         coeff_ready_q <= coeff_ready_d;
         out_valid_q   <= out_valid_d;
         out_data_q    <= out_data_d;
         out_chan_q    <= out_chan_d;
         chan_err_q    <= chan_err_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign coeff_ready = coeff_ready_q;
   assign out_valid   = out_valid_q;
   assign out_data    = out_data_q;
   assign out_chan    = out_chan_q;
   assign chan_err    = chan_err_q;

endmodule

// File: tb/tb_compensation_fir_mc.sv
// Directed scoreboard bench: instance A is single-channel 16-bit, instance B is 3-channel decimating.
module tb_compensation_fir_mc;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   typedef struct {
      logic signed [31:0] d;
      logic signed [31:0] ch;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];
   exp_t ea, eb;
   int   n_cmp = 0;
   int   n_fail = 0;

   logic signed [15:0] in_data_a, coeff_data_a, out_data_a;
   logic [0:0]         in_chan_a, out_chan_a;
   logic [3:0]         coeff_addr_a;
   logic               in_valid_a, in_ready_a, coeff_we_a, coeff_ready_a;
   logic               out_valid_a, out_ready_a, chan_err_a;

   logic signed [31:0] in_data_b, out_data_b;
   logic signed [15:0] coeff_data_b;
   logic [1:0]         in_chan_b, out_chan_b;
   logic [1:0]         coeff_addr_b;
   logic               in_valid_b, in_ready_b, coeff_we_b, coeff_ready_b;
   logic               out_valid_b, out_ready_b, chan_err_b;

   compensation_fir_mc #(
      .WIDTH(16), .COEFF_WIDTH(16), .TAPS(16), .NCH(1), .DECIM(1), .FRAC_BITS(14)
   ) dut_a (
      .clk(clk), .rst(rst),
      .in_data(in_data_a), .in_chan(in_chan_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
      .coeff_we(coeff_we_a), .coeff_addr(coeff_addr_a), .coeff_data(coeff_data_a),
      .coeff_ready(coeff_ready_a),
      .out_data(out_data_a), .out_chan(out_chan_a), .out_valid(out_valid_a),
      .out_ready(out_ready_a), .chan_err(chan_err_a)
   );

   compensation_fir_mc #(
      .WIDTH(32), .COEFF_WIDTH(16), .TAPS(4), .NCH(3), .DECIM(4), .FRAC_BITS(14)
   ) dut_b (
      .clk(clk), .rst(rst),
      .in_data(in_data_b), .in_chan(in_chan_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
      .coeff_we(coeff_we_b), .coeff_addr(coeff_addr_b), .coeff_data(coeff_data_b),
      .coeff_ready(coeff_ready_b),
      .out_data(out_data_b), .out_chan(out_chan_b), .out_valid(out_valid_b),
      .out_ready(out_ready_b), .chan_err(chan_err_b)
   );

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Output-side scoreboards: pop one expectation per completed handshake
   always @(negedge clk) begin
      if (!rst && out_valid_a && out_ready_a) begin
         if (q_a.size() == 0) chk("a_unexpected_out", 32'(out_valid_a), 0);
         else begin
            ea = q_a.pop_front();
            chk("a_out_data", out_data_a, ea.d);
            chk("a_out_chan", 32'(out_chan_a), ea.ch);
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && out_valid_b && out_ready_b) begin
         if (q_b.size() == 0) chk("b_unexpected_out", 32'(out_valid_b), 0);
         else begin
            eb = q_b.pop_front();
            chk("b_out_data", out_data_b, eb.d);
            chk("b_out_chan", 32'(out_chan_b), eb.ch);
         end
      end
   end

   task automatic send_a(input logic signed [15:0] d, input bit push, input logic signed [31:0] e);
      int n = 0;
      while (!in_ready_a && n < 200) begin step(); n++; end
      if (!in_ready_a) chk("a_in_ready_wait", 32'(in_ready_a), 1);
      in_data_a  = d;
      in_valid_a = 1'b1;
      if (push) q_a.push_back('{d: e, ch: 0});
      step();
      in_valid_a = 1'b0;
   endtask

   task automatic send_b(input logic [1:0] ch, input logic signed [31:0] d, input bit push,
                         input logic signed [31:0] e);
      int n = 0;
      while (!in_ready_b && n < 200) begin step(); n++; end
      if (!in_ready_b) chk("b_in_ready_wait", 32'(in_ready_b), 1);
      in_chan_b  = ch;
      in_data_b  = d;
      in_valid_b = 1'b1;
      if (push) q_b.push_back('{d: e, ch: 32'(ch)});
      step();
      in_valid_b = 1'b0;
   endtask

   task automatic wcoef_a(input logic [3:0] addr, input logic signed [15:0] d);
      int n = 0;
      while (!coeff_ready_a && n < 200) begin step(); n++; end
      coeff_we_a = 1'b1; coeff_addr_a = addr; coeff_data_a = d;
      step();
      coeff_we_a = 1'b0;
   endtask

   task automatic wcoef_b(input logic [1:0] addr, input logic signed [15:0] d);
      int n = 0;
      while (!coeff_ready_b && n < 200) begin step(); n++; end
      coeff_we_b = 1'b1; coeff_addr_b = addr; coeff_data_b = d;
      step();
      coeff_we_b = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((q_a.size() != 0 || q_b.size() != 0) && n < 400) begin step(); n++; end
      chk("drain_a_left", q_a.size(), 0);
      chk("drain_b_left", q_b.size(), 0);
      step();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: observed no finish, expected finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int  n;
      bit  seen;
      rst = 1'b1;
      in_data_a = '0; in_chan_a = '0; in_valid_a = 0; coeff_we_a = 0;
      coeff_addr_a = '0; coeff_data_a = '0; out_ready_a = 1'b1;
      in_data_b = '0; in_chan_b = '0; in_valid_b = 0; coeff_we_b = 0;
      coeff_addr_b = '0; coeff_data_b = '0; out_ready_b = 1'b1;
      step(); step();

      chk("a_rst_in_ready", 32'(in_ready_a), 1);
      chk("a_rst_coeff_ready", 32'(coeff_ready_a), 1);
      chk("a_rst_out_valid", 32'(out_valid_a), 0);
      chk("a_rst_out_data", out_data_a, 0);
      chk("a_rst_out_chan", 32'(out_chan_a), 0);
      chk("a_rst_chan_err", 32'(chan_err_a), 0);
      chk("b_rst_in_ready", 32'(in_ready_b), 1);
      chk("b_rst_coeff_ready", 32'(coeff_ready_b), 1);
      chk("b_rst_out_valid", 32'(out_valid_b), 0);
      chk("b_rst_out_data", out_data_b, 0);
      chk("b_rst_out_chan", 32'(out_chan_b), 0);
      chk("b_rst_chan_err", 32'(chan_err_b), 0);
      rst = 1'b0;

      // Passthrough and latency
      send_a(16'sd1000, 1, 1000);
      n = 0;
      while (!out_valid_a && n < 50) begin step(); n++; end
      chk("a_latency_edges", n, 17);
      drain();
      send_a(-16'sd5, 1, -5);
      drain();

      // Moving sum over 16 taps
      do_reset();
      for (int i = 0; i < 16; i++) wcoef_a(4'(i), 16'sh4000);
      for (int i = 1; i <= 20; i++) send_a(16'sd100, 1, ((i < 16) ? i : 16) * 100);
      drain();

      // Rounding
      do_reset();
      wcoef_a(4'd0, 16'sh2000);
      send_a(16'sd3, 1, 2);
      send_a(-16'sd3, 1, -1);
      drain();

      // Saturation both rails
      do_reset();
      for (int i = 0; i < 16; i++) wcoef_a(4'(i), 16'sh4000);
      for (int i = 0; i < 16; i++) send_a(16'sh7FFF, 1, 32767);
      drain();
      do_reset();
      for (int i = 0; i < 16; i++) wcoef_a(4'(i), 16'sh4000);
      for (int i = 0; i < 16; i++) send_a(16'sh8000, 1, -32768);
      drain();

      // Multi-channel decimation with independent histories
      do_reset();
      for (int i = 0; i < 4; i++) wcoef_b(2'(i), 16'sh4000);
      for (int i = 0; i < 8; i++) begin
         send_b(2'd0, 32'sd10, (i % 4) == 3, 40);
         send_b(2'd1, -32'sd20, (i % 4) == 3, -80);
      end
      drain();

      // Backpressure, busy coefficient write dropped
      do_reset();
      out_ready_b = 1'b0;
      for (int i = 0; i < 4; i++) send_b(2'd0, 32'sd7, i == 3, 7);
      coeff_we_b = 1'b1; coeff_addr_b = 2'd0; coeff_data_b = 16'sh1000;
      chk("b_coeff_ready_busy", 32'(coeff_ready_b), 0);
      step();
      coeff_we_b = 1'b0;
      n = 0;
      while (!out_valid_b && n < 50) begin step(); n++; end
      chk("b_valid_under_bp", 32'(out_valid_b), 1);
      for (int i = 0; i < 10; i++) begin
         chk("b_bp_data_stable", out_data_b, 7);
         chk("b_bp_valid_held", 32'(out_valid_b), 1);
         chk("b_bp_in_ready", 32'(in_ready_b), 0);
         step();
      end
      out_ready_b = 1'b1;
      drain();
      for (int i = 0; i < 4; i++) send_b(2'd0, 32'sd50, i == 3, 50);
      drain();

      // Out-of-range channel
      send_b(2'd3, 32'sd999, 0, 0);
      chk("b_chan_err_pulse", 32'(chan_err_b), 1);
      step();
      chk("b_chan_err_clear", 32'(chan_err_b), 0);

      // Reset during MAC
      wcoef_b(2'd0, 16'sh2000);
      for (int i = 0; i < 4; i++) send_b(2'd1, 32'sd30, 0, 0);
      chk("b_busy_after_trig", 32'(in_ready_b), 0);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("b_in_ready_after_rst", 32'(in_ready_b), 1);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin seen |= out_valid_b; step(); end
      chk("b_no_valid_after_rst", 32'(seen), 0);
      for (int i = 0; i < 4; i++) send_b(2'd1, 32'sd30, i == 3, 30);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
